// File: rtl/rv_imm_pkg.sv
// rtl/rv_imm_pkg.sv - immediate format encodings and parameter checks shared by the imm stage
package rv_imm_pkg;

  typedef logic [2:0] imm_src_t;

  localparam imm_src_t IMM_I     = 3'b000;
  localparam imm_src_t IMM_S     = 3'b001;
  localparam imm_src_t IMM_B     = 3'b010;
  localparam imm_src_t IMM_J     = 3'b011;
  localparam imm_src_t IMM_U     = 3'b100;
  localparam imm_src_t IMM_SHAMT = 3'b101;
  localparam imm_src_t IMM_ZIMM  = 3'b110;
  localparam imm_src_t IMM_ILL   = 3'b111;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational RISC-V immediate extraction and extension to XLEN
module imm_extract
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_src_t        src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Formats are assembled at 64 bits and truncated, so one mux serves both widths.
  logic [63:0] wide;
  logic [63:0] s;

  assign s = {64{instr[31]}};

  always_comb begin
    wide = '0;
    err  = 1'b0;
    case (src)
      IMM_I:     wide = {s[63:12], instr[31:20]};
      IMM_S:     wide = {s[63:12], instr[31:25], instr[11:7]};
      IMM_B:     wide = {s[63:12], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:     wide = {s[63:20], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:     wide = {s[63:32], instr[31:12], 12'b0};
      IMM_SHAMT: wide = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      IMM_ZIMM:  wide = {59'b0, instr[19:15]};
      default: begin
        wide = '0;
        err  = 1'b1;
      end
    endcase
  end

  assign imm = wide[XLEN-1:0];

  logic unused_opcode;
  assign unused_opcode = |instr[6:0];

  if (XLEN < 64) begin : g_sink_hi
    logic unused_hi;
    assign unused_hi = |wide[63:XLEN];
  end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with a one-entry skid buffer and sideband tag
module imm_gen_stage
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  imm_src_t         in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_gen_stage: TAG_W must be at least 1");
  end

  logic [XLEN-1:0]  new_imm;
  logic             new_err;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (in_instr),
    .src   (in_src),
    .imm   (new_imm),
    .err   (new_err)
  );

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;
  logic             accept;
  logic             out_free;

  // Ready depends only on the skid flop, breaking any combinational path from out_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // A full skid blocks accept, so draining it never races with a new entry.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_imm    <= skid_imm;
        out_tag    <= skid_tag;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_imm   <= new_imm;
        out_tag   <= in_tag;
        out_err   <= new_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= new_imm;
      skid_tag   <= in_tag;
      skid_err   <= new_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench driving 32- and 64-bit stages in lockstep
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_src = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, vld32, err32, rdy64, vld64, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tag32, tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [7:0]  tag;
    logic        err;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_err(err32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_err(err64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit x64);
    logic [63:0] r;
    r = {64{ins[31]}};
    case (src)
      3'd0: r[11:0] = ins[31:20];
      3'd1: begin r[11:5] = ins[31:25]; r[4:0] = ins[11:7]; end
      3'd2: begin r[11] = ins[7]; r[10:5] = ins[30:25]; r[4:1] = ins[11:8]; r[0] = 1'b0; end
      3'd3: begin r[19:12] = ins[19:12]; r[11] = ins[20]; r[10:1] = ins[30:21]; r[0] = 1'b0; end
      3'd4: begin r[31:12] = ins[31:12]; r[11:0] = 12'h000; end
      3'd5: begin r = '0; r[4:0] = ins[24:20]; if (x64) r[5] = ins[25]; end
      3'd6: begin r = '0; r[4:0] = ins[19:15]; end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check_state();
    exp_t e;
    chk("in_ready32", {63'b0, rdy32}, {63'b0, q.size() < 2});
    chk("in_ready64", {63'b0, rdy64}, {63'b0, q.size() < 2});
    chk("out_valid32", {63'b0, vld32}, {63'b0, q.size() > 0});
    chk("out_valid64", {63'b0, vld64}, {63'b0, q.size() > 0});
    if (q.size() > 0) begin
      e = q[0];
      chk("imm32", {32'b0, imm32}, {32'b0, e.i32});
      chk("imm64", imm64, e.i64);
      chk("tag32", {56'b0, tag32}, {56'b0, e.tag});
      chk("tag64", {56'b0, tag64}, {56'b0, e.tag});
      chk("err32", {63'b0, err32}, {63'b0, e.err});
      chk("err64", {63'b0, err64}, {63'b0, e.err});
    end
  endtask

  // One clock: check at negedge, drive, then advance the model across the posedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [7:0] tag, input logic ordy, input logic fl,
                       input logic ovr, input logic [31:0] e32, input logic [63:0] e64,
                       output logic accepted);
    exp_t e;
    logic [63:0] m32;
    check_state();
    in_valid  = v;
    in_instr  = ins;
    in_src    = src;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    accepted  = v && (q.size() < 2) && !fl;
    m32   = ref_imm(ins, src, 1'b0);
    e.i32 = ovr ? e32 : m32[31:0];
    e.i64 = ovr ? e64 : ref_imm(ins, src, 1'b1);
    e.tag = tag;
    e.err = (src == 3'd7);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (accepted) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag,
                          input logic [31:0] e32, input logic [63:0] e64);
    logic a;
    cycle(1'b1, ins, src, tag, 1'b1, 1'b0, 1'b1, e32, e64, a);
  endtask

  task automatic idle(input logic ordy);
    logic a;
    cycle(1'b0, 32'h0, 3'd0, 8'h0, ordy, 1'b0, 1'b0, 32'h0, 64'h0, a);
  endtask

  initial begin
    logic a;
    int budget;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {62'b0, vld32, vld64}, 64'd0);
    chk("rst_ready", {62'b0, rdy32, rdy64}, 64'd3);
    chk("rst_imm", imm64 | {32'b0, imm32}, 64'd0);
    chk("rst_tag_err", {46'b0, tag32, tag64, err32, err64}, 64'd0);
    rst = 1'b0;

    directed(32'hFFF00093, 3'd0, 8'h10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    directed(32'hFE000EE3, 3'd2, 8'h11, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    directed(32'h008000EF, 3'd3, 8'h12, 32'h00000008, 64'h0000000000000008);
    directed(32'h800000B7, 3'd4, 8'h13, 32'h80000000, 64'hFFFFFFFF80000000);
    directed(32'h03F01093, 3'd5, 8'h14, 32'h0000001F, 64'h000000000000003F);
    directed(32'hFFFFFFFF, 3'd6, 8'h15, 32'h0000001F, 64'h000000000000001F);
    directed(32'hFFFFFFFF, 3'd7, 8'h16, 32'h00000000, 64'h0000000000000000);
    directed(32'h12345678, 3'd7, 8'h17, 32'h00000000, 64'h0000000000000000);
    directed(32'h7FF00F23, 3'd1, 8'h18, 32'h000007FE, 64'h00000000000007FE);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: tags 1,2 fill output and skid, tag 3 waits for ready.
    cycle(1'b1, 32'h00100093, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0, 0, 0, a);
    cycle(1'b1, 32'h00200093, 3'd0, 8'd2, 1'b0, 1'b0, 1'b0, 0, 0, a);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00300093, 3'd0, 8'd3, 1'b0, 1'b0, 1'b0, 0, 0, a);
    chk("held_tag3", {63'b0, a}, 64'd0);
    budget = 0;
    a = 1'b0;
    while (!a && budget < 10) begin
      cycle(1'b1, 32'h00300093, 3'd0, 8'd3, 1'b1, 1'b0, 1'b0, 0, 0, a);
      budget++;
    end
    chk("tag3_accepted", {63'b0, a}, 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Flush with skid full and a simultaneous offer.
    cycle(1'b1, 32'h00500093, 3'd0, 8'd5, 1'b0, 1'b0, 1'b0, 0, 0, a);
    cycle(1'b1, 32'h00600093, 3'd0, 8'd6, 1'b0, 1'b0, 1'b0, 0, 0, a);
    cycle(1'b1, 32'h00700093, 3'd0, 8'd7, 1'b1, 1'b1, 1'b0, 0, 0, a);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Asynchronous reset between edges while stalled with two entries.
    cycle(1'b1, 32'h00800093, 3'd0, 8'd8, 1'b0, 1'b0, 1'b0, 0, 0, a);
    cycle(1'b1, 32'h00900093, 3'd0, 8'd9, 1'b0, 1'b0, 1'b0, 0, 0, a);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {62'b0, vld32, vld64}, 64'd0);
    chk("arst_ready", {62'b0, rdy32, rdy64}, 64'd3);
    chk("arst_imm", imm64 | {32'b0, imm32}, 64'd0);
    chk("arst_tag_err", {46'b0, tag32, tag64, err32, err64}, 64'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    directed(32'hFFF00093, 3'd0, 8'h20, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);

    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 1'b0, 0, 0, a);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Parametrised successor to the decode-stage sign extender.
- Extracts and extends RISC-V immediates for I/S/B/J/U, shift-amount and CSR-zimm formats to XLEN bits.
- Registers the result behind a valid/ready elastic stage with a one-entry skid buffer, so decode can be back-pressured by execute without a combinational ready path.
- Carries an opaque sideband tag (PC/rd) alongside each result.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried with each entry; minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_src  in  3  immediate format select (encoding below).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the entry on out_imm.
- out_err  out  1  entry was issued with an illegal in_src.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_imm=0, out_tag=0, out_err=0, in_ready=1, skid empty. Outputs hold these values for as long as rst is high.
- Format encoding; s = instr[31] replicated to fill XLEN:
  - 000 I: {s, instr[31:20]}
  - 001 S: {s, instr[31:25], instr[11:7]}
  - 010 B: {s, instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: {s, instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {s, instr[31:12], 12'b0}. With XLEN=64, bits 63:32 equal instr[31].
  - 101 SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 110 ZIMM: zero-extended instr[19:15].
  - 111: out_imm=0 and out_err=1 for that entry.
- Accept occurs when in_valid && in_ready at a rising edge. Latency is 1: the accepted entry appears on out_* after that edge.
- Storage is two entries: the output register and the skid register. Entries leave in acceptance order.
- in_ready is driven from registered state only (equal to skid empty). There is no combinational path from out_ready or in_valid to in_ready.
- While out_valid && !out_ready, out_imm, out_tag and out_err hold stable.
- Edge-case cases per rising edge:
  - Output empty, accept: entry goes to the output register.
  - Output full, out_ready=1, accept: new entry replaces the output register.
  - Output full, out_ready=0, accept: entry goes to skid; in_ready=0 from the next cycle.
  - Skid full, out_ready=1: skid moves to the output register and skid empties; in_ready=1 from the next cycle. No accept is possible in this cycle because in_ready=0.
  - Output full, out_ready=1, no accept, skid empty: out_valid=0.
- flush=1 at an edge: out_valid=0, skid empty, in_ready=1 after the edge. An in_valid in the same cycle is discarded. flush has priority over accept and over drain.
- Reset asserted mid-transfer discards all entries immediately. The first accept occurs at the first edge after rst deasserts.
- in_instr bits not used by the selected format are don't-care; they must not affect out_imm.

Decomposition:
- Shared package rv_imm_pkg holds:
  - the 3-bit imm_src encoding constants: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_ILL;
  - the XLEN legality check.
- Sub-module imm_extract: purely combinational format mux, parametrised by XLEN, producing {imm, err}. It is instantiated once at the stage input.
- The skid/handshake logic lives in imm_gen_stage itself.

Test Plan:
- XLEN=32, in_instr=0xFFF00093, src=I, out_ready=1 → one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_err=0.
- XLEN=32, in_instr=0xFE000EE3 (beq -4), src=B → out_imm=0xFFFFFFFC; in_instr=0x008000EF (jal +8), src=J → out_imm=0x00000008.
- XLEN=64, in_instr=0x800000B7 (lui 0x80000), src=U → out_imm=0xFFFFFFFF80000000; in_instr=0x03F01093, src=SHAMT → out_imm=0x3F.
- Back-pressure: out_ready=0, offer tags 1, 2, 3 on consecutive cycles → tag 1 on output, tag 2 in skid, in_ready=0 with tag 3 held; then out_ready=1 → tags 1, 2, 3 emerged in order, no drop or duplicate, outputs stable while stalled.
- Skid full, flush=1 with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the flushed cycle's entry never appears.
- src=111 on any instruction → out_imm=0, out_err=1. Separately, rst pulsed mid-stall (asynchronously, between edges) → out_valid=0 and in_ready=1 immediately, before the next edge.
